// File: rtl/dac_sched_pkg.sv
// Shared types and sizing for the DAC trigger scheduler.
package dac_sched_pkg;
  localparam int NUM_DAC   = 8;
  localparam int DAC_IDX_W = 3;
  localparam int WIDTH_W   = 16;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, HOLDOFF} dac_state_e;

  // Frame count to load at pulse start; width 0 behaves as width 1.
  function automatic logic [WIDTH_W-1:0] pulse_last(input logic [WIDTH_W-1:0] w);
    return (w == '0) ? '0 : w - WIDTH_W'(1);
  endfunction
endpackage

// File: rtl/dac_trigger_channel.sv
// One DAC's trigger sequencer: armed on grant, pulses for N frames, then blanks.
module dac_trigger_channel
  import dac_sched_pkg::*;
#(
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic               dataclk,
  input  logic               reset,
  input  logic               enable,
  input  logic               frame_tick,
  input  logic               grant,
  input  logic               abort,
  input  logic [WIDTH_W-1:0] width,
  output logic               idle,
  output logic               trig_value,
  output logic               trig_bypass,
  output logic               busy
);
  localparam logic [WIDTH_W-1:0] HOLD_LAST =
    WIDTH_W'(HOLDOFF_FRAMES > 0 ? HOLDOFF_FRAMES - 1 : 0);

  dac_state_e         state, state_nxt;
  logic [WIDTH_W-1:0] cnt, cnt_nxt, last, last_nxt;
  logic               kill;

  assign kill = !enable || abort;
  assign idle = (state == IDLE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    last_nxt  = last;
    if (kill) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (grant) begin
          state_nxt = ARMED;
          last_nxt  = pulse_last(width);
        end
        ARMED: if (frame_tick) begin
          state_nxt = ACTIVE;
          cnt_nxt   = last;
        end
        ACTIVE: if (frame_tick) begin
          if (cnt == '0) begin
            if (HOLDOFF_FRAMES == 0) state_nxt = IDLE;
            else begin
              state_nxt = HOLDOFF;
              cnt_nxt   = HOLD_LAST;
            end
          end else cnt_nxt = cnt - WIDTH_W'(1);
        end
        HOLDOFF: if (frame_tick) begin
          if (cnt == '0) state_nxt = IDLE;
          else cnt_nxt = cnt - WIDTH_W'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs trail the state by a cycle, but abort/disable drop them at once.
  always_ff @(posedge dataclk) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= '0;
      last        <= '0;
      trig_value  <= 1'b0;
      trig_bypass <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      last        <= last_nxt;
      trig_value  <= !kill && (state == ACTIVE);
      trig_bypass <= !kill && (state == ACTIVE || state == HOLDOFF);
      busy        <= !kill && (state != IDLE);
    end
  end
endmodule

// File: rtl/dac_trigger_scheduler.sv
// Round-robin sharing of the eight DAC trigger-bypass paths among NUM_REQ requesters.
module dac_trigger_scheduler
  import dac_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int FRAME_STATE    = 99,
  parameter int HOLDOFF_FRAMES = 2
) (
  input  logic                         dataclk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic [31:0]                  main_state,
  input  logic [5:0]                   channel,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [DAC_IDX_W*NUM_REQ-1:0] req_dac,
  input  logic [WIDTH_W*NUM_REQ-1:0]   req_width,
  input  logic [NUM_DAC-1:0]           dac_abort,
  output logic [NUM_DAC-1:0]           Trigger_value,
  output logic [NUM_DAC-1:0]           Trigger_bypass,
  output logic [NUM_DAC-1:0]           dac_busy,
  output logic                         frame_tick
);
  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0][DAC_IDX_W-1:0] dac_sel;
  logic [NUM_REQ-1:0][WIDTH_W-1:0]   wid_sel;
  logic [NUM_REQ-1:0]                elig;
  logic [NUM_DAC-1:0]                idle, grant;
  logic [WIDTH_W-1:0]                grant_width;
  logic [PTR_W-1:0]                  ptr, ptr_nxt, idx;
  logic [PTR_W:0]                    sum;
  logic                              found;

  assign dac_sel = req_dac;
  assign wid_sel = req_width;

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++)
      elig[i] = reset && enable && req_valid[i] && idle[dac_sel[i]] && !dac_abort[dac_sel[i]];
  end

  // First eligible requester at or after ptr, wrapping.
  always_comb begin
    req_ready = '0;
    ptr_nxt   = ptr;
    found     = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) sum = sum - (PTR_W+1)'(NUM_REQ);
      idx = sum[PTR_W-1:0];
      if (!found && elig[idx]) begin
        found          = 1'b1;
        req_ready[idx] = 1'b1;
        ptr_nxt        = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + PTR_W'(1);
      end
    end
  end

  // Only one grant per cycle, so a single width bus serves every channel.
  always_comb begin
    grant       = '0;
    grant_width = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (req_ready[i]) begin
        grant[dac_sel[i]] = 1'b1;
        grant_width       = wid_sel[i];
      end
  end

  always_ff @(posedge dataclk) begin
    if (!reset) begin
      ptr        <= '0;
      frame_tick <= 1'b0;
    end else begin
      ptr        <= ptr_nxt;
      frame_tick <= (main_state == 32'(FRAME_STATE)) && (channel == '0);
    end
  end

  for (genvar d = 0; d < NUM_DAC; d++) begin : g_dac
    dac_trigger_channel #(.HOLDOFF_FRAMES(HOLDOFF_FRAMES)) u_ch (
      .dataclk     (dataclk),
      .reset       (reset),
      .enable      (enable),
      .frame_tick  (frame_tick),
      .grant       (grant[d]),
      .abort       (dac_abort[d]),
      .width       (grant_width),
      .idle        (idle[d]),
      .trig_value  (Trigger_value[d]),
      .trig_bypass (Trigger_bypass[d]),
      .busy        (dac_busy[d])
    );
  end
endmodule
